// File: rtl/ascon_uart_host.sv
// ascon_uart_host
// Host-side initiator for the FPGA ASCON UART link. Drives the byte side of a
// local uart_core: sends one encryption job (K/N/A/W fields plus a G command)
// and then collects the returned 128-bit tag and WAVE_BYTES-byte cipher.
//
// Ports:
//   clock_i, reset_i        clock and synchronous active-high reset
//   start_i                 one-cycle job launch, honoured only when idle
//   key_i/nonce_i/ad_i/wave_i  job payload, captured on the accepted start
//   TxBusy_i, RXRdy_i, RXErr_i, RxData_i  status and receive data from uart_core
//   TxByte_o, Load_o        byte and one-cycle load strobe to uart_core
//   Tag_o, Cipher_o         received tag and cipher (first byte ends up on top)
//   Busy_o, Done_o, Err_o   job in progress, completion pulse, sticky error
//
// Optional feature macro: ASCON_HOST_TAG_CHECK_EN adds Exp_tag_i / Tag_ok_o and
// compares the received tag against the expected one at completion.

module ascon_uart_host #(
  parameter int WAVE_BYTES = 184,
  parameter int RX_TIMEOUT = 5_000_000
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [127:0]            key_i,
  input  logic [127:0]            nonce_i,
  input  logic [63:0]             ad_i,
  input  logic [WAVE_BYTES*8-1:0] wave_i,
  input  logic                    TxBusy_i,
  input  logic                    RXRdy_i,
  input  logic                    RXErr_i,
  input  logic [7:0]              RxData_i,
`ifdef ASCON_HOST_TAG_CHECK_EN
  input  logic [127:0]            Exp_tag_i,
  output logic                    Tag_ok_o,
`endif
  output logic [7:0]              TxByte_o,
  output logic                    Load_o,
  output logic [127:0]            Tag_o,
  output logic [WAVE_BYTES*8-1:0] Cipher_o,
  output logic                    Busy_o,
  output logic                    Done_o,
  output logic                    Err_o
);

  localparam int WAVE_W = WAVE_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE, TX_LOAD, TX_HOLD, RX_TAG, RX_CIPHER, DONE, ERR
  } state_t;

  state_t             state_q;
  logic [127:0]       key_q;
  logic [127:0]       nonce_q;
  logic [63:0]        ad_q;
  logic [WAVE_W-1:0]  wave_q;
  logic [2:0]         field_q;
  logic [7:0]         byteCnt_q;
  logic [1:0]         hold_q;
  logic [7:0]         rxCnt_q;
  logic [22:0]        timer_q;
  logic               rxRdyPrev_q;
  logic               rxStrobe_q;
`ifdef ASCON_HOST_TAG_CHECK_EN
  logic [127:0]       expTag_q;
`endif

  logic [7:0] cmdByte;
  logic [7:0] dataByte;
  logic [7:0] lastCnt;
  logic [7:0] txByte_d;
  logic       rxTimeout;

  // Pick the byte to send for the current field. Count 0 is the command
  // character; later counts take the top byte of that field's shadow register,
  // which is shifted left after every data byte so the MSB byte goes first.
  // lastCnt is the count of the final byte in the field (payload length).
  always_comb begin
    cmdByte  = 8'h47;
    dataByte = 8'h00;
    lastCnt  = 8'd0;
    case (field_q)
      3'd0: begin cmdByte = 8'h4B; dataByte = key_q[127:120];     lastCnt = 8'd16; end
      3'd1: begin cmdByte = 8'h4E; dataByte = nonce_q[127:120];   lastCnt = 8'd16; end
      3'd2: begin cmdByte = 8'h41; dataByte = ad_q[63:56];        lastCnt = 8'd8;  end
      3'd3: begin cmdByte = 8'h57; dataByte = wave_q[WAVE_W-1 -: 8]; lastCnt = 8'(WAVE_BYTES); end
      default: begin cmdByte = 8'h47; dataByte = 8'h00; lastCnt = 8'd0; end
    endcase
    txByte_d  = (byteCnt_q == 8'd0) ? cmdByte : dataByte;
    rxTimeout = (timer_q == 23'(RX_TIMEOUT));
  end

  // Whole job sequencer. A received byte is taken one cycle after the rising
  // edge of RXRdy_i (rxStrobe_q). RXErr_i pre-empts everything while a job is
  // active, so a byte arriving in the same cycle is simply lost. Load_o and
  // Done_o default low each cycle so they can only ever be single pulses.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      key_q       <= '0;
      nonce_q     <= '0;
      ad_q        <= '0;
      wave_q      <= '0;
      field_q     <= '0;
      byteCnt_q   <= '0;
      hold_q      <= '0;
      rxCnt_q     <= '0;
      timer_q     <= '0;
      rxRdyPrev_q <= 1'b0;
      rxStrobe_q  <= 1'b0;
      TxByte_o    <= '0;
      Load_o      <= 1'b0;
      Tag_o       <= '0;
      Cipher_o    <= '0;
      Busy_o      <= 1'b0;
      Done_o      <= 1'b0;
      Err_o       <= 1'b0;
`ifdef ASCON_HOST_TAG_CHECK_EN
      expTag_q    <= '0;
      Tag_ok_o    <= 1'b0;
`endif
    end else begin
      rxRdyPrev_q <= RXRdy_i;
      rxStrobe_q  <= RXRdy_i & ~rxRdyPrev_q;
      Load_o      <= 1'b0;
      Done_o      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            key_q     <= key_i;
            nonce_q   <= nonce_i;
            ad_q      <= ad_i;
            wave_q    <= wave_i;
            field_q   <= '0;
            byteCnt_q <= '0;
            hold_q    <= '0;
            Err_o     <= 1'b0;
            Tag_o     <= '0;
            Cipher_o  <= '0;
            Busy_o    <= 1'b1;
            state_q   <= TX_LOAD;
`ifdef ASCON_HOST_TAG_CHECK_EN
            expTag_q  <= Exp_tag_i;
            Tag_ok_o  <= 1'b0;
`endif
          end
        end
        DONE, ERR: state_q <= IDLE;
        default: begin
          if (RXErr_i) begin
            Err_o   <= 1'b1;
            Busy_o  <= 1'b0;
            state_q <= ERR;
          end else begin
            case (state_q)
              TX_LOAD: begin
                if (!TxBusy_i) begin
                  TxByte_o <= txByte_d;
                  Load_o   <= 1'b1;
                  hold_q   <= '0;
                  state_q  <= TX_HOLD;
                  if (byteCnt_q != 8'd0) begin
                    case (field_q)
                      3'd0: key_q   <= {key_q[119:0], 8'h00};
                      3'd1: nonce_q <= {nonce_q[119:0], 8'h00};
                      3'd2: ad_q    <= {ad_q[55:0], 8'h00};
                      3'd3: wave_q  <= {wave_q[WAVE_W-9:0], 8'h00};
                      default: ;
                    endcase
                  end
                end
              end
              TX_HOLD: begin
                // Fixed holdoff first so the UART has time to raise TxBusy_i.
                if (hold_q != 2'd2) begin
                  hold_q <= hold_q + 2'd1;
                end else if (!TxBusy_i) begin
                  if (byteCnt_q == lastCnt) begin
                    byteCnt_q <= '0;
                    if (field_q == 3'd4) begin
                      rxCnt_q <= '0;
                      timer_q <= '0;
                      state_q <= RX_TAG;
                    end else begin
                      field_q <= field_q + 3'd1;
                      state_q <= TX_LOAD;
                    end
                  end else begin
                    byteCnt_q <= byteCnt_q + 8'd1;
                    state_q   <= TX_LOAD;
                  end
                end
              end
              RX_TAG: begin
                if (rxStrobe_q) begin
                  Tag_o   <= {Tag_o[119:0], RxData_i};
                  timer_q <= '0;
                  if (rxCnt_q == 8'd15) begin
                    rxCnt_q <= '0;
                    state_q <= RX_CIPHER;
                  end else begin
                    rxCnt_q <= rxCnt_q + 8'd1;
                  end
                end else if (rxTimeout) begin
                  Err_o   <= 1'b1;
                  Busy_o  <= 1'b0;
                  state_q <= ERR;
                end else begin
                  timer_q <= timer_q + 23'd1;
                end
              end
              RX_CIPHER: begin
                if (rxStrobe_q) begin
                  Cipher_o <= {Cipher_o[WAVE_W-9:0], RxData_i};
                  timer_q  <= '0;
                  if (rxCnt_q == 8'(WAVE_BYTES - 1)) begin
                    Done_o  <= 1'b1;
                    Busy_o  <= 1'b0;
                    state_q <= DONE;
`ifdef ASCON_HOST_TAG_CHECK_EN
                    // Tag_o is already complete here; a wrong tag still
                    // finishes the job but is also flagged as an error.
                    Tag_ok_o <= (Tag_o == expTag_q);
                    if (Tag_o != expTag_q) Err_o <= 1'b1;
`endif
                  end else begin
                    rxCnt_q <= rxCnt_q + 8'd1;
                  end
                end else if (rxTimeout) begin
                  Err_o   <= 1'b1;
                  Busy_o  <= 1'b0;
                  state_q <= ERR;
                end else begin
                  timer_q <= timer_q + 23'd1;
                end
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
